// File: rtl/inst_decode_stage_pkg.sv
// Shared decode definitions: micro-command layout, ALU/memory/immediate codes,
// RV32 opcodes and the stage state encoding.
package decode_pkg;

  localparam int MICRO_W   = 16;
  localparam int REGEN_B   = 15;
  localparam int PCJEN_B   = 14;
  localparam int PCREN_B   = 13;
  localparam int MWEN_LSB  = 11;
  localparam int MREN_LSB  = 9;
  localparam int ALUOP_LSB = 5;
  localparam int UNSIGN_B  = 4;
  localparam int ARITH_B   = 3;
  localparam int IMM_LSB   = 0;
  localparam int MEM_W     = 2;
  localparam int ALUOP_W   = 4;
  localparam int IMM_W     = 3;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SL   = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_SR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_LESS = 4'd7;

  localparam logic [MEM_W-1:0] MEM_NONE = 2'd0;
  localparam logic [MEM_W-1:0] MEM_B    = 2'd1;
  localparam logic [MEM_W-1:0] MEM_H    = 2'd2;
  localparam logic [MEM_W-1:0] MEM_W32  = 2'd3;

  localparam logic [IMM_W-1:0] IMM_NONE = 3'd0;
  localparam logic [IMM_W-1:0] IMM_I    = 3'd1;
  localparam logic [IMM_W-1:0] IMM_S    = 3'd2;
  localparam logic [IMM_W-1:0] IMM_SB   = 3'd3;
  localparam logic [IMM_W-1:0] IMM_U    = 3'd4;
  localparam logic [IMM_W-1:0] IMM_UJ   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic               regen;
    logic               pcjen;
    logic               pcren;
    logic [MEM_W-1:0]   mwen;
    logic [MEM_W-1:0]   mren;
    logic [ALUOP_W-1:0] aluop;
    logic               unsign;
    logic               arith;
    logic [IMM_W-1:0]   imm_type;
  } micro_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  // Shared funct3 -> ALU mapping of OP and OP-IMM (SUB/SRA handled by caller).
  function automatic logic [ALUOP_W-1:0] alu_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SL;
      3'b010:  return ALU_LESS;
      3'b011:  return ALU_LESS;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SR;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface inst_decode_stage_if #(
  parameter int XLEN      = 32,
  parameter int MICRO_LEN = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [XLEN-1:0]      in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [MICRO_LEN-1:0] out_micro;
  logic [XLEN-1:0]      out_imm;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [4:0]           out_rd;
  logic [XLEN-1:0]      out_pc;
  logic                 out_illegal;
  logic                 out_ebreak;
  logic                 halted;
  logic                 resume;

  modport master (
    output in_valid, in_inst, in_pc, out_ready, resume,
    input  in_ready, out_valid, out_micro, out_imm, out_rs1, out_rs2, out_rd,
           out_pc, out_illegal, out_ebreak, halted
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, resume,
    output in_ready, out_valid, out_micro, out_imm, out_rs1, out_rs2, out_rd,
           out_pc, out_illegal, out_ebreak, halted
  );
endinterface

// File: rtl/inst_decode_core.sv
// Combinational RV32 decoder: instruction word -> micro-command, immediate,
// illegal and EBREAK flags.
module inst_decode_core import decode_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int EN_M_EXT = 0
) (
  input  logic [31:0]     inst,
  output micro_t          micro,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            ebreak
);
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  micro_t             m;
  logic               ill;
  logic signed [31:0] raw;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    m      = '0;
    ill    = 1'b0;
    ebreak = 1'b0;
    case (opc)
      OPC_LUI:   begin m.regen = 1'b1; m.imm_type = IMM_U; end
      OPC_AUIPC: begin m.regen = 1'b1; m.pcren = 1'b1; m.imm_type = IMM_U; end
      OPC_JAL:   begin m.regen = 1'b1; m.pcjen = 1'b1; m.pcren = 1'b1; m.imm_type = IMM_UJ; end
      OPC_JALR: begin
        m.regen = 1'b1; m.pcjen = 1'b1; m.imm_type = IMM_I;
        ill = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        m.pcjen = 1'b1; m.pcren = 1'b1; m.imm_type = IMM_SB; m.unsign = f3[1];
        case (f3)
          3'b000:         m.aluop = ALU_ADD;
          3'b001:         m.aluop = ALU_SUB;
          3'b100, 3'b110: m.aluop = ALU_OR;
          3'b101, 3'b111: m.aluop = ALU_XOR;
          default:        ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        m.regen = 1'b1; m.imm_type = IMM_I; m.unsign = f3[2];
        case (f3)
          3'b000, 3'b100: m.mren = MEM_B;
          3'b001, 3'b101: m.mren = MEM_H;
          3'b010:         m.mren = MEM_W32;
          default:        ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        m.imm_type = IMM_S;
        case (f3)
          3'b000:  m.mwen = MEM_B;
          3'b001:  m.mwen = MEM_H;
          3'b010:  m.mwen = MEM_W32;
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        m.regen = 1'b1; m.imm_type = IMM_I; m.aluop = alu_f3(f3);
        m.unsign = (f3 == 3'b011);
        // shift-immediates carry funct7 in the upper immediate bits
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      m.arith = 1'b1;
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OPC_OP: begin
        m.regen = 1'b1;
        if (f7 == 7'b0000000) begin
          m.aluop  = alu_f3(f3);
          m.unsign = (f3 == 3'b011);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          m.aluop = (f3 == 3'b000) ? ALU_SUB : ALU_SR;
          m.arith = 1'b1;
        end else if (f7 == 7'b0000001 && EN_M_EXT != 0) begin
          m.aluop = {1'b1, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) ebreak = 1'b1;
        else                     ill    = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    micro   = ill ? '0 : m;
    illegal = ill;
  end

  // illegal words have imm_type NONE, so their immediate is forced to zero here
  always_comb begin
    raw = '0;
    case (micro.imm_type)
      IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_SB:  raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   raw = {inst[31:12], 12'b0};
      IMM_UJ:  raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'(raw);
  end
endmodule

// File: rtl/inst_decode_stage.sv
// Registered decode stage: one-entry pipeline register with valid/ready on
// both sides and a RUN/HALT state entered on EBREAK or illegal instructions.
module inst_decode_stage import decode_pkg::*; #(
  parameter int XLEN            = 32,
  parameter int MICRO_LEN       = 16,
  parameter int EN_M_EXT        = 0,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input logic                clk,
  input logic                rst_n,
  inst_decode_stage_if.slave bus
);
  state_e               state, state_nxt;
  micro_t               dec_micro;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_ill, dec_ebreak;
  logic                 accept, halt_req;

  logic                 vld_q;
  logic [MICRO_LEN-1:0] micro_q;
  logic [XLEN-1:0]      imm_q, pc_q;
  logic [4:0]           rs1_q, rs2_q, rd_q;
  logic                 ill_q, ebreak_q;

  inst_decode_core #(.XLEN(XLEN), .EN_M_EXT(EN_M_EXT)) u_core (
    .inst    (bus.in_inst),
    .micro   (dec_micro),
    .imm     (dec_imm),
    .illegal (dec_ill),
    .ebreak  (dec_ebreak)
  );

  assign accept   = bus.in_valid & bus.in_ready;
  assign halt_req = dec_ebreak | (dec_ill & (HALT_ON_ILLEGAL != 0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // entering HALT wins over a coincident resume because resume is only seen in HALT
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (accept && halt_req) state_nxt = HALT;
      HALT: if (bus.resume)         state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.halted   = (state == HALT);
    bus.in_ready = rst_n && (state == RUN) && (!vld_q || bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      micro_q  <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      ill_q    <= 1'b0;
      ebreak_q <= 1'b0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      micro_q  <= dec_micro;
      imm_q    <= dec_imm;
      pc_q     <= bus.in_pc;
      rs1_q    <= bus.in_inst[19:15];
      rs2_q    <= bus.in_inst[24:20];
      rd_q     <= bus.in_inst[11:7];
      ill_q    <= dec_ill;
      ebreak_q <= dec_ebreak;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.out_micro   = micro_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = ill_q;
  assign bus.out_ebreak  = ebreak_q;
endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered, parametrised RV32 decode stage that replaces the purely combinational micro-command lookup with a single-entry pipeline register and valid/ready handshakes on both sides. It sits between instruction fetch and execute. It produces these outputs for each instruction it accepts:
- a micro-command,
- a sign-extended immediate,
- register indices,
- an illegal-instruction flag.

It adds optional M-extension decoding, exact (full-field) matching for SYSTEM and shift encodings, and a halt state entered on EBREAK or an illegal instruction.

## Interface
Parameters:
- XLEN, 32: datapath width; the immediate and PC are XLEN bits.
- MICRO_LEN, 16: micro-command width; fixed by the package layout and must equal 16.
- EN_M_EXT, 0: when 1, MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU decode as legal; when 0 they are illegal.
- HALT_ON_ILLEGAL, 1: when 1, an illegal instruction enters HALT; when 0 it passes with the flag set and the stage keeps running.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low (already decided)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of the instruction
- out_valid  out  1  decoded entry held
- out_ready  in  1  execute consumes the entry
- out_micro  out  MICRO_LEN  micro-command
- out_imm  out  XLEN  sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_pc  out  XLEN  PC passed through
- out_illegal  out  1  instruction matched no pattern
- out_ebreak  out  1  instruction is EBREAK
- halted  out  1  stage is in HALT
- resume  in  1  single-cycle pulse; returns from HALT to RUN

## Operation
- Micro layout:
  - [15] REGEN
  - [14] PCJEN
  - [13] PCREN
  - [12:11] MWEN
  - [10:9] MREN
  - [8:5] ALUOP
  - [4] UNSIGN
  - [3] ARITH
  - [2:0] IMM_TYPE
- ALUOP:
  - 0–7 keep the existing meanings: ADD/BEQ, SUB/BNE, SL, SR, OR/BLT, XOR/BGE, AND, LESS.
  - 8–15 = {1'b1, funct3} for M-extension ops.
- ARITH = 1 for SRA, SRAI and SUB. UNSIGN = 1 for BLTU, BGEU, LBU, LHU, SLTIU and SLTU (SLTIU is now correctly marked).
- Matching rules:
  - opcode[6:0] must match exactly, including bits [1:0] = 2'b11.
  - funct3 is checked for every type except U and J.
  - funct7 is checked for R-type and for SLLI/SRLI/SRAI.
  - EBREAK matches only the full word 32'h00100073.
  - Any other SYSTEM word, and any non-matching word, is illegal.
- Illegal instruction: out_micro = 0, out_imm = 0, out_illegal = 1.
- Immediate generation by IMM_TYPE:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - SB: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - UJ: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - All are sign-extended to XLEN. NONE gives 0.
- Register indices are always taken from the fixed instruction fields, regardless of type.
- State machine:
  - RUN → HALT when an entry with out_ebreak = 1 is accepted, or an entry with out_illegal = 1 is accepted and HALT_ON_ILLEGAL = 1. The transition happens in the same edge that loads that entry.
  - HALT → RUN on resume = 1.
  - In HALT, in_ready = 0. The held entry still drains normally.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N; out_valid is high from that cycle.
- in_ready = (state == RUN) && (!out_valid || out_ready). This allows full throughput of one instruction per cycle.
- Transfers happen only when valid && ready at a rising edge. Output fields hold steady while out_valid && !out_ready.
- Simultaneous accept and consume: the register is loaded with the new entry and out_valid stays 1.
- Consume with no new input: out_valid goes to 0. The payload registers keep their old values; do not use them.
- resume while in RUN: ignored.
- resume in the same cycle the HALT-causing entry is accepted: state stays in HALT; entering HALT takes priority.
- Reset (rst_n = 0 at an edge, including mid-stream):
  - state = RUN, out_valid = 0, halted = 0.
  - out_micro, out_imm, out_pc, out_rs1, out_rs2 and out_rd = 0.
  - out_illegal = 0, out_ebreak = 0.
  - Any held entry is discarded.
- in_ready is 0 during the reset cycle and 1 in the first cycle after reset.

## Structure
- Package decode_pkg holds:
  - field widths and offsets of the micro layout;
  - the ALUOP, MWEN/MREN, IMM_TYPE and opcode constants;
  - a micro_t packed struct;
  - a state enum {RUN, HALT}.
- One combinational sub-module, inst_decode_core. It maps inst → {micro, imm, illegal, ebreak} and is parametrised by XLEN and EN_M_EXT. It is written as a case on opcode and funct3, with no loop-based table scan.
- inst_decode_stage holds only the state register, the pipeline register and the handshake logic.

## Test plan
- ADDI: 32'h00500093 → out_micro = 16'h8001 (REGEN, I-type), out_imm = 5, rd = 1, out_illegal = 0, one cycle after acceptance.
- LUI / branch: 32'h123450B7 → out_imm = 32'h12345000, IMM_TYPE = U. 32'hFE000EE3 (BEQ, offset -4) → out_imm = 32'hFFFFFFFC.
- EBREAK: 32'h00100073 → out_ebreak = 1 and halted = 1 in the next cycle. in_ready stays 0 for 10 cycles. A resume pulse sets in_ready = 1 in the following cycle. 32'h00000073 (ECALL) → out_illegal = 1.
- M extension: 32'h02208033 (MUL x0, x1, x2) with EN_M_EXT = 0 → out_illegal = 1, halted = 1. With EN_M_EXT = 1 → ALUOP = 8, illegal = 0.
- Backpressure: stream 8 instructions with out_ready toggling pseudo-randomly → no loss or duplication, order preserved, outputs stable while stalled. With out_ready held at 1, throughput is one instruction per cycle.
- Reset mid-stream: assert rst_n = 0 with out_valid = 1 → next cycle out_valid = 0, halted = 0 and all payload outputs are 0.
